// File: rtl/escalonador_ativos_pkg.sv
// Shared definitions for the active-node scheduler.
//   estado_t : scheduler FSM states (idle / searching / full)
package escalonador_ativos_pkg;

  localparam int ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    ST_IDLE       = 2'd0,
    ST_PROCURANDO = 2'd1,
    ST_CHEIO      = 2'd2
  } estado_t;

endpackage

// File: rtl/escalonador_ativos_rr_seletor.sv
// rr_seletor: combinational round-robin free-slot finder.
// Scans i_livre starting at i_ptr upward, wrapping NUM_NA-1 -> 0, and
// reports the first free slot.
//   i_livre   in  NUM_NA  free-slot mask (1 = eligible)
//   i_ptr     in  IDX_W   scan start index (must be < NUM_NA)
//   o_found   out 1       a free slot exists
//   o_onehot  out NUM_NA  one-hot of chosen slot (0 if none)
//   o_idx     out IDX_W   index of chosen slot (0 if none)
module rr_seletor #(
  parameter int NUM_NA = 8,
  parameter int IDX_W  = $clog2(NUM_NA)
) (
  input  logic [NUM_NA-1:0] i_livre,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic              o_found,
  output logic [NUM_NA-1:0] o_onehot,
  output logic [IDX_W-1:0]  o_idx
);

  always_comb begin : scan
    logic [IDX_W:0] w_pos;
    o_found  = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    w_pos    = '0;
    for (int unsigned off = 0; off < NUM_NA; off++) begin
      // ptr + off < 2*NUM_NA, so one conditional subtract is the modulo
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(off);
      if (w_pos >= (IDX_W+1)'(NUM_NA)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_NA);
      end
      if (!o_found && i_livre[w_pos[IDX_W-1:0]]) begin
        o_found                     = 1'b1;
        o_onehot[w_pos[IDX_W-1:0]]  = 1'b1;
        o_idx                       = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/escalonador_ativos.sv
// escalonador_ativos: allocates active-node update requests to NUM_NA slots.
// Tracks an occupancy mask plus the address held by each slot and picks free
// slots round-robin. With `ESCALONADOR_DEDUP_EN defined, a request whose
// address is already held re-triggers the owning slot instead of allocating.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid_in/ready  request handshake; ready = idle
//   req_endereco_in     requested node address
//   desativar_in/idx    free slot idx at the next edge (any state)
//   habilitar_out       registered one-hot enable pulse to the chosen slot
//   ativo_out           occupancy mask
//   slot_endereco_out   packed per-slot addresses, slot i at [i*ADR_WIDTH +: ADR_WIDTH]
//   ocupacao_out        popcount of ativo_out
//   cheio_out/vazio_out mask all-ones / all-zeros
module escalonador_ativos
  import escalonador_ativos_pkg::*;
#(
  parameter int NUM_NA    = 8,
  parameter int ADR_WIDTH = 5,
  parameter int IDX_W     = $clog2(NUM_NA)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid_in,
  output logic                        req_ready_out,
  input  logic [ADR_WIDTH-1:0]        req_endereco_in,
  input  logic                        desativar_in,
  input  logic [IDX_W-1:0]            desativar_idx_in,
  output logic [NUM_NA-1:0]           habilitar_out,
  output logic [NUM_NA-1:0]           ativo_out,
  output logic [NUM_NA*ADR_WIDTH-1:0] slot_endereco_out,
  output logic [IDX_W:0]              ocupacao_out,
  output logic                        cheio_out,
  output logic                        vazio_out
);

  estado_t                     r_estado, w_prox_estado;
  logic [ADR_WIDTH-1:0]        r_endereco;
  logic [NUM_NA-1:0]           r_ativo;
  logic [NUM_NA-1:0]           r_habilitar;
  logic [NUM_NA*ADR_WIDTH-1:0] r_slot_end;
  logic [IDX_W-1:0]            r_ptr;

  logic [NUM_NA-1:0]           w_liberado;
  logic                        w_hit;
  logic [NUM_NA-1:0]           w_hit_onehot;
  logic                        w_found;
  logic [NUM_NA-1:0]           w_aloc_onehot;
  logic [IDX_W-1:0]            w_aloc_idx;
  logic [NUM_NA-1:0]           w_hab_prox;
  logic [NUM_NA-1:0]           w_set;
  logic [IDX_W-1:0]            w_ptr_prox;
  logic                        w_aceita;
  logic [IDX_W:0]              w_ocup;

  assign w_aceita = req_valid_in && (r_estado == ST_IDLE);

  always_comb begin
    w_liberado = '0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (desativar_in && (desativar_idx_in == IDX_W'(i))) begin
        w_liberado[i] = 1'b1;
      end
    end
  end

  // Registered mask excludes a slot freed this cycle: it still reads as
  // active, so it cannot be allocated until the following cycle.
  rr_seletor #(
    .NUM_NA (NUM_NA),
    .IDX_W  (IDX_W)
  ) u_rr_seletor (
    .i_livre  (~r_ativo),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_onehot (w_aloc_onehot),
    .o_idx    (w_aloc_idx)
  );

`ifdef ESCALONADOR_DEDUP_EN
  always_comb begin
    w_hit        = 1'b0;
    w_hit_onehot = '0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      if (!w_hit && r_ativo[i] && !w_liberado[i] &&
          (r_slot_end[i*ADR_WIDTH +: ADR_WIDTH] == r_endereco)) begin
        w_hit           = 1'b1;
        w_hit_onehot[i] = 1'b1;
      end
    end
  end
`else
  assign w_hit        = 1'b0;
  assign w_hit_onehot = '0;
`endif

  always_comb begin
    w_prox_estado = r_estado;
    w_hab_prox    = '0;
    w_set         = '0;
    w_ptr_prox    = r_ptr;
    case (r_estado)
      ST_IDLE: begin
        if (req_valid_in) w_prox_estado = ST_PROCURANDO;
      end
      ST_PROCURANDO: begin
        if (w_hit) begin
          w_hab_prox    = w_hit_onehot;
          w_prox_estado = ST_IDLE;
        end else if (w_found) begin
          w_hab_prox    = w_aloc_onehot;
          w_set         = w_aloc_onehot;
          w_ptr_prox    = (w_aloc_idx == IDX_W'(NUM_NA-1)) ? '0 : w_aloc_idx + 1'b1;
          w_prox_estado = ST_IDLE;
        end else begin
          w_prox_estado = ST_CHEIO;
        end
      end
      ST_CHEIO: begin
        // Also retry if a slot is already free: it may have been released in
        // the very cycle the search saw a full mask.
        if ((|(w_liberado & r_ativo)) || (|(~r_ativo))) begin
          w_prox_estado = ST_PROCURANDO;
        end
      end
      default: w_prox_estado = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= ST_IDLE;
      r_endereco  <= '0;
      r_ativo     <= '0;
      r_habilitar <= '0;
      r_slot_end  <= '0;
      r_ptr       <= '0;
    end else begin
      r_estado    <= w_prox_estado;
      r_habilitar <= w_hab_prox;
      r_ptr       <= w_ptr_prox;
      // Allocation targets only slots already free, so set-after-clear is safe.
      r_ativo     <= (r_ativo & ~w_liberado) | w_set;
      if (w_aceita) r_endereco <= req_endereco_in;
      for (int unsigned i = 0; i < NUM_NA; i++) begin
        if (w_set[i]) r_slot_end[i*ADR_WIDTH +: ADR_WIDTH] <= r_endereco;
      end
    end
  end

  always_comb begin
    w_ocup = '0;
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      w_ocup = w_ocup + (IDX_W+1)'(r_ativo[i]);
    end
  end

  assign req_ready_out     = (r_estado == ST_IDLE);
  assign habilitar_out     = r_habilitar;
  assign ativo_out         = r_ativo;
  assign slot_endereco_out = r_slot_end;
  assign ocupacao_out      = w_ocup;
  assign cheio_out         = &r_ativo;
  assign vazio_out         = ~|r_ativo;

endmodule

// File: tb/tb_escalonador_ativos.sv
// Self-checking bench for escalonador_ativos (NUM_NA=8, ADR_WIDTH=5).
// Expected enable pulses are queued at each handshake and checked when the
// DUT pulses; expectations follow `ESCALONADOR_DEDUP_EN when defined.
module tb_escalonador_ativos;

  logic        clk;
  logic        rst_n;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [4:0]  req_endereco_in;
  logic        desativar_in;
  logic [2:0]  desativar_idx_in;
  logic [7:0]  habilitar_out;
  logic [7:0]  ativo_out;
  logic [39:0] slot_endereco_out;
  logic [3:0]  ocupacao_out;
  logic        cheio_out;
  logic        vazio_out;

  escalonador_ativos #(.NUM_NA(8), .ADR_WIDTH(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_in      (req_valid_in),
    .req_ready_out     (req_ready_out),
    .req_endereco_in   (req_endereco_in),
    .desativar_in      (desativar_in),
    .desativar_idx_in  (desativar_idx_in),
    .habilitar_out     (habilitar_out),
    .ativo_out         (ativo_out),
    .slot_endereco_out (slot_endereco_out),
    .ocupacao_out      (ocupacao_out),
    .cheio_out         (cheio_out),
    .vazio_out         (vazio_out)
  );

  typedef struct {
    logic [7:0] hab;
    int         due;
  } esp_t;

  typedef struct {
    logic [4:0] adr;
    logic [7:0] hab;
    logic [7:0] ativo;
    logic [3:0] ocup;
  } vec_t;

  esp_t fila[$];
  esp_t e_mon;
  vec_t tabela[4];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, act, exp);
    end
  endtask

  // Scoreboard: pop an expectation whenever the DUT pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (habilitar_out != 8'h00) begin
        if (fila.size() == 0) begin
          chk("unexpected_pulse", habilitar_out, 0);
        end else begin
          e_mon = fila.pop_front();
          chk("hab", habilitar_out, e_mon.hab);
          if (e_mon.due >= 0) chk("hab_latency", cyc, e_mon.due);
        end
      end else if (fila.size() != 0 && fila[0].due >= 0 && cyc > fila[0].due) begin
        chk("hab_missing", 0, fila[0].hab);
        void'(fila.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !req_ready_out; i++) tick();
    if (!req_ready_out) chk("ready_timeout", req_ready_out, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && fila.size() != 0; i++) tick();
    if (fila.size() != 0) begin
      chk("drain_timeout", fila.size(), 0);
      fila.delete();
    end
  endtask

  // Handshake happens at the next edge; the pulse is visible one edge later.
  task automatic send(input logic [4:0] adr, input logic [7:0] hab, input bit timed);
    esp_t e;
    wait_ready();
    req_valid_in    = 1'b1;
    req_endereco_in = adr;
    e.hab = hab;
    e.due = timed ? cyc + 2 : -1;
    fila.push_back(e);
    tick();
    req_valid_in = 1'b0;
  endtask

  task automatic liberar(input logic [2:0] idx);
    desativar_in     = 1'b1;
    desativar_idx_in = idx;
    tick();
    desativar_in     = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, req_ready_out, 1);
    chk({tag, "_ativo"}, ativo_out, 8'h00);
    chk({tag, "_hab"}, habilitar_out, 8'h00);
    chk({tag, "_ocup"}, ocupacao_out, 0);
    chk({tag, "_vazio"}, vazio_out, 1);
    chk({tag, "_cheio"}, cheio_out, 0);
    chk({tag, "_slot_end"}, slot_endereco_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [39:0] se;
    logic [7:0]  oh;
    int          primeiro;

    tabela[0] = '{adr: 5'h03, hab: 8'h01, ativo: 8'h01, ocup: 4'd1};
    tabela[1] = '{adr: 5'h07, hab: 8'h02, ativo: 8'h03, ocup: 4'd2};
    tabela[2] = '{adr: 5'h0A, hab: 8'h04, ativo: 8'h07, ocup: 4'd3};
`ifdef ESCALONADOR_DEDUP_EN
    tabela[3] = '{adr: 5'h07, hab: 8'h02, ativo: 8'h07, ocup: 4'd3};
    primeiro  = 3;
`else
    tabela[3] = '{adr: 5'h07, hab: 8'h08, ativo: 8'h0F, ocup: 4'd4};
    primeiro  = 4;
`endif

    rst_n = 1'b0; req_valid_in = 1'b0; req_endereco_in = '0;
    desativar_in = 1'b0; desativar_idx_in = '0;
    tick(); tick(); tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("post_rst");

    for (int v = 0; v < 4; v++) begin
      send(tabela[v].adr, tabela[v].hab, 1'b1);
      wait_drain();
      chk($sformatf("vec%0d_ativo", v), ativo_out, tabela[v].ativo);
      chk($sformatf("vec%0d_ocup", v), ocupacao_out, tabela[v].ocup);
    end
    se = slot_endereco_out;
    chk("slot2_addr", se[2*5 +: 5], 5'h0A);

    // Fill remaining slots in round-robin order.
    for (int i = primeiro; i < 8; i++) begin
      oh = 8'h01 << i;
      send(5'h10 + 5'(i), oh, 1'b1);
    end
    wait_drain();
    chk("full_ativo", ativo_out, 8'hFF);
    chk("full_cheio", cheio_out, 1);
    chk("full_vazio", vazio_out, 0);
    chk("full_ocup", ocupacao_out, 8);

    // Request with all slots busy parks in the full state.
    send(5'h11, 8'h20, 1'b0);
    tick(); tick();
    chk("cheio_ready", req_ready_out, 0);
    chk("cheio_no_pulse_yet", fila.size(), 1);
    liberar(3'd5);
    wait_drain();
    chk("realloc5_ativo", ativo_out, 8'hFF);
    se = slot_endereco_out;
    chk("slot5_addr", se[5*5 +: 5], 5'h11);

    // Pointer now 6; slots 6,7 busy -> must wrap to slot 0 (not 3).
    liberar(3'd0);
    liberar(3'd3);
    tick();
    chk("freed_ativo", ativo_out, 8'hF6);
    se = slot_endereco_out;
    chk("slot0_retained", se[0 +: 5], 5'h03);
    liberar(3'd3);
    tick();
    chk("free_inactive_noop", ativo_out, 8'hF6);
    send(5'h1E, 8'h01, 1'b1);
    wait_drain();
    chk("wrap_ativo", ativo_out, 8'hF7);

    // Slot 2 freed in the search cycle: no hit, next free slot (3) allocated.
    wait_ready();
    begin
      esp_t e;
      req_valid_in    = 1'b1;
      req_endereco_in = 5'h0A;
      e.hab = 8'h08;
      e.due = cyc + 2;
      fila.push_back(e);
      tick();
      req_valid_in = 1'b0;
      liberar(3'd2);
    end
    wait_drain();
    chk("freehit_ativo", ativo_out, 8'hFB);

    // Async reset while searching drops the request.
    wait_ready();
    req_valid_in    = 1'b1;
    req_endereco_in = 5'h1F;
    tick();
    req_valid_in = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset_vals("midrst");
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_hab", habilitar_out, 8'h00);
    chk("midrst_ativo", ativo_out, 8'h00);
    send(5'h05, 8'h01, 1'b1);
    wait_drain();
    chk("after_rst_ativo", ativo_out, 8'h01);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
